dmem_ctrl: RTL
==============

# dmem_ctrl

Multi-core data-memory controller: the initiator side of the shared data RAM bus (ADDBUS/DATAIN/DATAOUT/WR/RD). It arbitrates round-robin among NCORES core load/store ports and sequences each access into a setup/access/response cycle pattern that the level-sensitive RAM read and clocked RAM write require. It returns read data and a one-cycle acknowledge to the winning core. It sits between the core datapaths and the single data RAM instance.

## Interface
- NCORES, 4: number of requesting cores (2..8)
- AW, 16: address width
- DW, 16: data width
- MEM_DEPTH, 1024: number of implemented RAM words; higher addresses are out of range
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_req  in  NCORES  per-core request; held high with we/addr/wdata stable until ack
- core_we  in  NCORES  1 = store, 0 = load
- core_addr  in  NCORES*AW  packed addresses, core i at [i*AW +: AW]
- core_wdata  in  NCORES*DW  packed store data
- core_ack  out  NCORES  one-hot, one-cycle completion pulse
- core_rdata  out  DW  load data; valid in the ack cycle, held until next load completes
- core_err  out  1  high with ack when the address was out of range
- ADDBUS  out  AW  RAM address
- DATAIN  out  DW  RAM write data
- DATAOUT  in  DW  RAM read data (tri-stated by the RAM when RD = 0)
- WR  out  1  RAM write enable
- RD  out  1  RAM read enable

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any core_req bit is set, the round-robin arbiter picks the first requester at or after rr_ptr (wrapping modulo NCORES). Latch the grantee index, we, addr, and wdata, then go to SETUP. rr_ptr becomes grantee+1 mod NCORES.
- SETUP: drive ADDBUS = latched addr and DATAIN = latched wdata; RD = WR = 0. This makes the address stable before RD rises. Go to ACCESS.
- ACCESS, load: RD = 1. At the closing edge, capture DATAOUT into core_rdata.
- ACCESS, store: WR = 1; the RAM commits at the closing edge.
- ACCESS, out of range (addr >= MEM_DEPTH): RD = WR = 0, no RAM access, and core_rdata <= 0.
- Every ACCESS goes to RESP.
- RESP: core_ack[grantee] = 1; core_err = out-of-range flag. RD = WR = 0. Go to IDLE.
- ADDBUS/DATAIN hold their last driven value outside SETUP/ACCESS; they change only when a new grant is latched.
- A core that still has core_req high in the cycle after its ack is treated as a new request.
- The latched address and data are used, so changes on the core inputs after the grant do not affect the access in flight.

## Timing
- Reset values: state IDLE, rr_ptr 0, core_ack 0, core_err 0, core_rdata 0, ADDBUS 0, DATAIN 0, WR 0, RD 0.
- Latency: if req is sampled high in IDLE at edge N, the SETUP cycle follows, then ACCESS, and ack is high in the cycle after edge N+2 (RESP).
- Throughput: one access per 4 cycles, because RESP always returns to IDLE.
- Simultaneous requests: exactly one grant per IDLE; no request is starved longer than NCORES-1 other accesses.
- Reset during ACCESS: WR/RD clear immediately (asynchronously), so a store is not committed if rst_n falls before the closing edge. No ack is issued, and the core must reissue its request.
- Reset during RESP: the ack is dropped.
- The RD rising edge must always be preceded by at least one cycle of stable ADDBUS; this is guaranteed by SETUP.

## Structure
- Shared package dmem_pkg: state enum (IDLE/SETUP/ACCESS/RESP), AW/DW defaults, MEM_DEPTH constant.
- Sub-module rr_arbiter, parameterised on NCORES:
  - inputs: req vector, rr_ptr
  - outputs: grant index and a valid flag
  - purely combinational
- rr_ptr register and all sequencing live in dmem_ctrl.

## Test plan
- Single load: after reset, RAM preloaded mem[0]=10; core 0 reads addr 0 → ADDBUS=0 in SETUP, RD=1 for exactly one cycle, core_ack=0001 and core_rdata=10 three cycles after req.
- Store then load: core 2 writes 0x1234 to addr 5, then reads addr 5 → WR high for one cycle with ADDBUS=5, DATAIN=0x1234; the following read returns 0x1234 with ack=0100.
- Contention: all four cores request in the same cycle with rr_ptr=0 → acks in order 0,1,2,3, each 4 cycles apart. Then cores 3 and 0 request → core 0 is served first (rr_ptr wrapped to 0).
- Out of range: core 1 loads addr 1024 → RD and WR stay 0 throughout, core_ack=0010, core_err=1, core_rdata=0.
- Reset mid-store: rst_n falls during the ACCESS of a store of 0xBEEF to addr 7 → WR drops immediately, no ack is issued, and after reset mem[7] is unchanged. All outputs are at their reset values while rst_n is low.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: default widths,
// implemented RAM depth and the sequencing state encoding.
package dmem_pkg;

  localparam int unsigned NCORES_DEF    = 4;
  localparam int unsigned AW_DEF        = 16;
  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned MEM_DEPTH_DEF = 1024;

  // Access sequencing states (IDLE -> SETUP -> ACCESS -> RESP -> IDLE)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/dmem_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req         per-core request vector
//   rr_ptr      highest-priority core index for this decision
//   grant_idx   first requesting core at or after rr_ptr (wrapping)
//   grant_valid any request present
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NCORES = NCORES_DEF
) (
  input  logic [NCORES-1:0]         req,
  input  logic [$clog2(NCORES)-1:0] rr_ptr,
  output logic [$clog2(NCORES)-1:0] grant_idx,
  output logic                      grant_valid
);

  localparam int unsigned IW = $clog2(NCORES);

  // Scan from farthest offset down to offset 0 so the nearest requester
  // at or after rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_idx   = '0;
    grant_valid = |req;
    for (int unsigned k = NCORES; k >= 1; k--) begin
      if (req[IW'((32'(rr_ptr) + k - 1) % NCORES)]) begin
        grant_idx = IW'((32'(rr_ptr) + k - 1) % NCORES);
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-core data-memory controller: round-robin arbitration among core
// load/store ports, sequenced onto the shared RAM bus as
// SETUP (address stable) / ACCESS (RD or WR) / RESP (ack) cycles.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   core_req/we/addr/wdata      per-core request side (packed per core)
//   core_ack/rdata/err          completion pulse, load data, range error
//   ADDBUS/DATAIN/WR/RD         RAM address, write data and strobes
//   DATAOUT                     RAM read data
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned NCORES    = NCORES_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    core_req,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0]    core_ack,
  output logic [DW-1:0]        core_rdata,
  output logic                 core_err,
  output logic [AW-1:0]        ADDBUS,
  output logic [DW-1:0]        DATAIN,
  input  logic [DW-1:0]        DATAOUT,
  output logic                 WR,
  output logic                 RD
);

  localparam int unsigned IW = $clog2(NCORES);

  state_t            state_q,  state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     gnt_q,    gnt_d;
  logic              we_q,     we_d;
  logic              oor_q,    oor_d;
  logic [AW-1:0]     addr_q,   addr_d;
  logic [DW-1:0]     wdata_q,  wdata_d;
  logic [DW-1:0]     rdata_q,  rdata_d;
  logic              wr_q,     wr_d;
  logic              rd_q,     rd_d;
  logic              err_q,    err_d;
  logic [NCORES-1:0] ack_q,    ack_d;

  logic [IW-1:0]     arb_idx;
  logic              arb_valid;

  logic [AW-1:0]     addr_arr  [NCORES];
  logic [DW-1:0]     wdata_arr [NCORES];

  // Per-core views of the packed request buses
  for (genvar i = 0; i < NCORES; i++) begin : g_unpack
    assign addr_arr[i]  = core_addr[i*AW +: AW];
    assign wdata_arr[i] = core_wdata[i*DW +: DW];
  end

  rr_arbiter #(
    .NCORES (NCORES)
  ) u_arb (
    .req         (core_req),
    .rr_ptr      (rr_ptr_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    err_d    = 1'b0;
    ack_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          // Latch the whole request; the core inputs are ignored until ack
          gnt_d    = arb_idx;
          we_d     = core_we[arb_idx];
          addr_d   = addr_arr[arb_idx];
          wdata_d  = wdata_arr[arb_idx];
          oor_d    = (64'(addr_arr[arb_idx]) >= 64'(MEM_DEPTH));
          rr_ptr_d = (arb_idx == IW'(NCORES - 1)) ? '0 : arb_idx + IW'(1);
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        // Strobes rise one cycle after the address was placed on ADDBUS
        rd_d    = !we_q && !oor_q;
        wr_d    = we_q && !oor_q;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (oor_q) begin
          rdata_d = '0;
        end else if (!we_q) begin
          rdata_d = DATAOUT;
        end
        ack_d   = NCORES'(1) << gnt_q;
        err_d   = oor_q;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
    end
  end

  // The latched request drives the RAM bus directly, so ADDBUS/DATAIN
  // only move when a new grant is taken.
  assign ADDBUS     = addr_q;
  assign DATAIN     = wdata_q;
  assign WR         = wr_q;
  assign RD         = rd_q;
  assign core_ack   = ack_q;
  assign core_err   = err_q;
  assign core_rdata = rdata_q;

endmodule
